// File: rtl/game_pkg.sv
// Shared encodings for the tic-tac-toe turn controller: cell codes, winner codes,
// FSM states and the board type.
package game_pkg;

    localparam int NUM_CELLS = 9;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        J1    = 2'b01,
        PC    = 2'b10
    } cell_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_J1   = 2'b01,
        WIN_PC   = 2'b10,
        WIN_DRAW = 2'b11
    } winner_t;

    typedef enum logic [2:0] {
        WAIT_PL,
        PL_WRITE,
        PL_CHECK,
        PC_WAIT,
        PC_WRITE,
        PC_CHECK,
        DONE
    } state_t;

    typedef logic [NUM_CELLS-1:0][1:0] board_t;

    // Write strobe for a cell index; out-of-range indices produce no strobe.
    function automatic logic [15:0] onehot16(input logic [3:0] pos);
        return (pos < 4'(NUM_CELLS)) ? (16'(1) << pos) : 16'h0000;
    endfunction

endpackage

// File: rtl/line_checker.sv
// Flags a completed row, column or diagonal owned by one player code.
module line_checker
    import game_pkg::*;
(
    input  board_t board_i,
    input  cell_t  player_i,
    output logic   win_o
);

    logic [NUM_CELLS-1:0] own;

    always_comb begin
        own = '0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            own[i] = (board_i[i] == player_i);
        end
    end

    assign win_o = (own[0] & own[1] & own[2]) |
                   (own[3] & own[4] & own[5]) |
                   (own[6] & own[7] & own[8]) |
                   (own[0] & own[3] & own[6]) |
                   (own[1] & own[4] & own[7]) |
                   (own[2] & own[5] & own[8]) |
                   (own[0] & own[4] & own[8]) |
                   (own[2] & own[4] & own[6]);

endmodule

// File: rtl/game_turn_fsm.sv
// Turn sequencer for player J1 versus the computer: validates J1 moves, waits
// PC_DELAY cycles, then takes the free cell offered by find_space.
module game_turn_fsm
    import game_pkg::*;
#(
    parameter int unsigned PC_DELAY = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        player_move,
    input  logic [3:0]  player_pos,
    input  logic        put_random,
    input  logic [3:0]  position_random,
    output logic [15:0] PL_en,
    output logic [15:0] PC_en,
    output logic        illegal_move,
    output logic        turn,
    output logic        game_over,
    output logic [1:0]  winner
);

    state_t      state_q, state_d;
    board_t      board_q, board_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  pl_pos_q, pl_pos_d;
    logic [3:0]  pc_pos_q, pc_pos_d;
    logic [15:0] pl_en_q, pl_en_d;
    logic [15:0] pc_en_q, pc_en_d;
    logic        illegal_q, illegal_d;
    logic        turn_q, turn_d;
    logic        game_over_q, game_over_d;
    winner_t     winner_q, winner_d;

    logic j1_win, pc_win, board_full, pl_free;

    line_checker u_chk_j1 (.board_i(board_q), .player_i(J1), .win_o(j1_win));
    line_checker u_chk_pc (.board_i(board_q), .player_i(PC), .win_o(pc_win));

    always_comb begin
        board_full = 1'b1;
        pl_free    = 1'b0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (board_q[i] == EMPTY) board_full = 1'b0;
            if (player_pos == 4'(i) && board_q[i] == EMPTY) pl_free = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        board_d   = board_q;
        cnt_d     = cnt_q;
        pl_pos_d  = pl_pos_q;
        pc_pos_d  = pc_pos_q;
        winner_d  = winner_q;
        illegal_d = 1'b0;

        case (state_q)
            WAIT_PL: begin
                if (player_move) begin
                    if (pl_free) begin
                        pl_pos_d = player_pos;
                        state_d  = PL_WRITE;
                    end else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            PL_WRITE: begin
                for (int i = 0; i < NUM_CELLS; i++) begin
                    if (pl_pos_q == 4'(i)) board_d[i] = J1;
                end
                state_d = PL_CHECK;
            end
            PL_CHECK: begin
                if (j1_win) begin
                    state_d  = DONE;
                    winner_d = WIN_J1;
                end else if (board_full) begin
                    state_d  = DONE;
                    winner_d = WIN_DRAW;
                end else begin
                    state_d = PC_WAIT;
                    cnt_d   = '0;
                end
            end
            PC_WAIT: begin
                if (cnt_q == 4'(PC_DELAY - 1)) begin
                    if (put_random) begin
                        // Latched on entry so the registered strobe lines up with PC_WRITE.
                        pc_pos_d = position_random;
                        state_d  = PC_WRITE;
                    end else begin
                        state_d  = DONE;
                        winner_d = WIN_DRAW;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            PC_WRITE: begin
                for (int i = 0; i < NUM_CELLS; i++) begin
                    if (pc_pos_q == 4'(i)) board_d[i] = PC;
                end
                state_d = PC_CHECK;
            end
            PC_CHECK: begin
                if (pc_win) begin
                    state_d  = DONE;
                    winner_d = WIN_PC;
                end else if (board_full) begin
                    state_d  = DONE;
                    winner_d = WIN_DRAW;
                end else begin
                    state_d = WAIT_PL;
                end
            end
            DONE:    state_d = DONE;
            default: state_d = WAIT_PL;
        endcase

        // Outputs are registered from the next state so they align with it.
        pl_en_d     = (state_d == PL_WRITE) ? onehot16(pl_pos_d) : 16'h0000;
        pc_en_d     = (state_d == PC_WRITE) ? onehot16(pc_pos_d) : 16'h0000;
        turn_d      = (state_d != WAIT_PL);
        game_over_d = (state_d == DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= WAIT_PL;
            board_q     <= '0;
            cnt_q       <= '0;
            pl_pos_q    <= '0;
            pc_pos_q    <= '0;
            pl_en_q     <= '0;
            pc_en_q     <= '0;
            illegal_q   <= 1'b0;
            turn_q      <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= WIN_NONE;
        end else begin
            state_q     <= state_d;
            board_q     <= board_d;
            cnt_q       <= cnt_d;
            pl_pos_q    <= pl_pos_d;
            pc_pos_q    <= pc_pos_d;
            pl_en_q     <= pl_en_d;
            pc_en_q     <= pc_en_d;
            illegal_q   <= illegal_d;
            turn_q      <= turn_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
        end
    end

    assign PL_en        = pl_en_q;
    assign PC_en        = pc_en_q;
    assign illegal_move = illegal_q;
    assign turn         = turn_q;
    assign game_over    = game_over_q;
    assign winner       = 2'(winner_q);

endmodule

// File: tb/tb_game_turn_fsm.sv
// Scoreboard bench: a board-level game model predicts strobe/illegal/end events,
// a monitor pops and compares them as the DUT emits them.
module tb_game_turn_fsm;

    localparam int PC_DELAY = 4;
    localparam logic [1:0] EV_PL = 2'd0, EV_PC = 2'd1, EV_ILL = 2'd2, EV_DONE = 2'd3;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] val;
        logic        turn;
    } ev_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        player_move;
    logic [3:0]  player_pos;
    logic        put_random;
    logic [3:0]  position_random;
    logic [15:0] PL_en, PC_en;
    logic        illegal_move, turn, game_over;
    logic [1:0]  winner;

    game_turn_fsm #(.PC_DELAY(PC_DELAY)) dut (
        .clock(clock), .reset(reset), .player_move(player_move), .player_pos(player_pos),
        .put_random(put_random), .position_random(position_random),
        .PL_en(PL_en), .PC_en(PC_en), .illegal_move(illegal_move), .turn(turn),
        .game_over(game_over), .winner(winner)
    );

    always #5 clock = ~clock;

    int  checks = 0;
    int  errors = 0;
    ev_t expq[$];

    // find_space environment: tracks strobes, offers the lowest free cell
    logic [1:0] fs_board [9];
    logic       nospace;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 9; i++) fs_board[i] <= 2'd0;
        end else begin
            for (int i = 0; i < 9; i++) begin
                if (PL_en[i]) fs_board[i] <= 2'd1;
                if (PC_en[i]) fs_board[i] <= 2'd2;
            end
        end
    end

    always_comb begin
        put_random      = 1'b0;
        position_random = 4'd0;
        for (int i = 8; i >= 0; i--) begin
            if (fs_board[i] == 2'd0) begin
                put_random      = 1'b1;
                position_random = 4'(i);
            end
        end
        if (nospace) put_random = 1'b0;
    end

    // Reference game model
    int mboard [9];
    bit mover;
    int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                         '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    function automatic bit mwin(input int p);
        for (int l = 0; l < 8; l++)
            if (mboard[lines[l][0]] == p && mboard[lines[l][1]] == p && mboard[lines[l][2]] == p)
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit mfull();
        for (int i = 0; i < 9; i++) if (mboard[i] == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int mfirst();
        for (int i = 0; i < 9; i++) if (mboard[i] == 0) return i;
        return -1;
    endfunction

    task automatic push(input logic [1:0] k, input logic [15:0] v, input logic t);
        ev_t e;
        e.kind = k; e.val = v; e.turn = t;
        expq.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor
    int  cyc = 0;
    int  last_pl = 0;
    bit  go_prev = 1'b0;

    task automatic got(input logic [1:0] k, input logic [15:0] v);
        ev_t e;
        checks++;
        if (expq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind %0d val %0h, expected none at %0t", k, v, $time);
        end else begin
            e = expq.pop_front();
            if (e.kind !== k || e.val !== v || e.turn !== turn) begin
                errors++;
                $display("FAIL event: got kind %0d val %0h turn %0b, expected kind %0d val %0h turn %0b at %0t",
                         k, v, turn, e.kind, e.val, e.turn, $time);
            end
        end
    endtask

    always @(negedge clock) begin
        if (reset) begin
            go_prev = 1'b0;
        end else begin
            cyc++;
            if (PL_en != 16'h0) begin
                got(EV_PL, PL_en);
                last_pl = cyc;
            end
            if (PC_en != 16'h0) begin
                got(EV_PC, PC_en);
                chk("pc_latency", 32'(cyc - last_pl), 32'(PC_DELAY + 2));
            end
            if (illegal_move) got(EV_ILL, 16'h0);
            if (game_over && !go_prev) got(EV_DONE, {14'h0, winner});
            go_prev = game_over;
        end
    end

    // Stimulus
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_PL_en"}, 32'(PL_en), 32'h0);
        chk({tag, "_PC_en"}, 32'(PC_en), 32'h0);
        chk({tag, "_illegal"}, 32'(illegal_move), 32'h0);
        chk({tag, "_turn"}, 32'(turn), 32'h0);
        chk({tag, "_game_over"}, 32'(game_over), 32'h0);
        chk({tag, "_winner"}, 32'(winner), 32'h0);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 9; i++) mboard[i] = 0;
        mover   = 1'b0;
        nospace = 1'b0;
    endtask

    task automatic do_reset();
        repeat (3) tick();
        chk("queue_drained", 32'(expq.size()), 32'h0);
        expq.delete();
        reset = 1'b1;
        #1;
        check_zero("rst");
        clear_model();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic play_move(input int pos, input bit nsp, input bit poke, input bit abort);
        bit legal, ending;
        int f;
        legal  = (pos < 9) && (mboard[pos] == 0);
        ending = 1'b0;
        nospace = nsp;
        if (!legal) begin
            push(EV_ILL, 16'h0, 1'b0);
        end else begin
            mboard[pos] = 1;
            push(EV_PL, 16'(1) << pos, 1'b1);
            if (mwin(1)) begin
                push(EV_DONE, 16'd1, 1'b1); mover = 1'b1; ending = 1'b1;
            end else if (mfull()) begin
                push(EV_DONE, 16'd3, 1'b1); mover = 1'b1; ending = 1'b1;
            end else if (!abort) begin
                if (nsp) begin
                    push(EV_DONE, 16'd3, 1'b1); mover = 1'b1;
                end else begin
                    f = mfirst();
                    mboard[f] = 2;
                    push(EV_PC, 16'(1) << f, 1'b1);
                    if (mwin(2)) begin
                        push(EV_DONE, 16'd2, 1'b1); mover = 1'b1;
                    end else if (mfull()) begin
                        push(EV_DONE, 16'd3, 1'b1); mover = 1'b1;
                    end
                end
            end
        end
        player_pos  = 4'(pos);
        player_move = 1'b1;
        tick();
        player_move = 1'b0;
        if (abort) begin
            repeat (3) tick();
            chk("mid_wait_turn", 32'(turn), 32'h1);
            reset = 1'b1;
            #1;
            check_zero("mid_rst");
            clear_model();
            tick();
            reset = 1'b0;
            tick();
            return;
        end
        if (legal && !ending && poke) begin
            tick(); tick();
            player_pos  = 4'($urandom_range(0, 15));
            player_move = 1'b1;
            tick();
            player_move = 1'b0;
        end
        for (int i = 0; i < 40; i++) begin
            if (!turn || game_over) break;
            tick();
        end
        if (turn && !game_over) begin
            errors++;
            $display("FAIL turn_timeout: turn still %0b, expected 0 within 40 cycles", turn);
        end
        nospace = 1'b0;
    endtask

    task automatic done_pokes();
        repeat (2) begin
            player_pos  = 4'($urandom_range(0, 15));
            player_move = 1'b1;
            tick();
            player_move = 1'b0;
            tick();
        end
        chk("done_hold_go", 32'(game_over), 32'h1);
    endtask

    initial begin
        reset = 1'b1; player_move = 1'b0; player_pos = 4'd0;
        clear_model();
        #1;
        check_zero("init");
        tick(); tick();
        reset = 1'b0;
        tick();

        play_move(4, 0, 1, 0);                 // PL 0x0010, PC 0x0001, poke in PC_WAIT
        play_move(4, 0, 0, 0);                 // repeat -> illegal
        play_move(9, 0, 0, 0);                 // out of range -> illegal
        play_move(0, 0, 0, 0);                 // PC-owned cell -> illegal

        do_reset();                            // J1 wins column 2,5,8
        play_move(2, 0, 0, 0); play_move(5, 0, 0, 0); play_move(8, 0, 0, 0);
        done_pokes();
        chk("j1_winner", 32'(winner), 32'h1);

        do_reset();                            // PC wins row 0,1,2
        play_move(8, 0, 0, 0); play_move(5, 0, 0, 0); play_move(7, 0, 0, 0);
        chk("pc_winner", 32'(winner), 32'h2);

        do_reset();                            // board fills with no line
        play_move(1, 0, 0, 0); play_move(4, 0, 0, 0); play_move(5, 0, 0, 0);
        play_move(6, 0, 0, 0); play_move(8, 0, 0, 0);
        chk("draw_full", 32'(winner), 32'h3);

        do_reset();                            // find_space reports no room
        play_move(4, 1, 0, 0);
        chk("draw_nospace", 32'(winner), 32'h3);

        do_reset();                            // reset mid PC_WAIT, then normal move
        play_move(3, 0, 0, 1);
        play_move(0, 0, 0, 0);

        for (int g = 0; g < 30; g++) begin
            do_reset();
            for (int m = 0; m < 25 && !mover; m++)
                play_move($urandom_range(0, 10), $urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)), 0);
            if (mover) done_pokes();
        end

        repeat (3) tick();
        chk("final_queue", 32'(expq.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end, expected completion before 500000");
        $fatal(1, "watchdog");
    end

endmodule
